uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CNTR_W, default 32, giving the width of the bit-timing counter.
REQ-002 SHALL have parameter SOURCE_CLK, default 12000000, giving the hwclk frequency in Hz.
REQ-003 SHALL have parameter TARGET_CLK, default 9600, giving the baud rate in Hz.
REQ-004 SHALL derive CLKS_PER_BIT = SOURCE_CLK/TARGET_CLK (integer division) and HALF_BIT = CLKS_PER_BIT/2, which is 1250 and 625 at the defaults.
REQ-005 SHALL have port hwclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port ftdi_rx, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-008 SHALL have port rx_data, output, 8 bits: the received byte.
REQ-009 SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-010 SHALL have port rx_ready, input, 1 bit: the consumer accepts the byte in any cycle where rx_valid && rx_ready.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-012 SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed byte is dropped.

Function
REQ-013 SHALL pass ftdi_rx through a 2-flop synchronizer whose flops reset to 1; all decisions use the synchronized value (rx_s).
REQ-014 SHALL implement the states IDLE, START, DATA and STOP.
REQ-015 IDLE: SHALL go to START and clear the counter on an rx_s 1->0 transition; a line held low SHALL NOT start a new frame.
REQ-016 START: SHALL sample rx_s when the counter reaches HALF_BIT-1; if rx_s is 1 (glitch), SHALL return to IDLE with no output activity; if rx_s is 0, SHALL go to DATA with the counter cleared and the bit index at 0.
REQ-017 DATA: SHALL sample rx_s every CLKS_PER_BIT cycles (counter == CLKS_PER_BIT-1) into a shift register, LSB first; after the 8th sample, SHALL go to STOP.
REQ-018 STOP: SHALL sample rx_s after CLKS_PER_BIT cycles and return to IDLE in the same cycle.
REQ-019 On a stop sample of 1, SHALL complete the byte; on a stop sample of 0, SHALL pulse frame_err, discard the byte, and leave rx_valid and rx_data unchanged.
REQ-020 The stop sample SHALL occur HALF_BIT + 9*CLKS_PER_BIT cycles after the cycle in which the falling edge is seen on rx_s.
REQ-021 rx_valid and the new rx_data SHALL appear in the cycle after the stop sample.
REQ-022 The counter SHALL be CNTR_W bits wide and SHALL never wrap within a frame.
REQ-023 rx_valid SHALL stay high with rx_data stable until an accept occurs; on accept, rx_valid SHALL fall the next cycle unless a new byte completes in that same cycle.
REQ-024 If a byte completes while rx_valid is 1 and no accept occurs that cycle, SHALL pulse overrun, drop the new byte, and keep the old rx_data.
REQ-025 If a byte completes in the same cycle as an accept, SHALL load the new byte, hold rx_valid at 1, and SHALL NOT pulse overrun.
REQ-026 The receiver SHALL keep receiving regardless of rx_valid and rx_ready; there is no backpressure to the line.
REQ-027 Parameters with CLKS_PER_BIT < 4 are unsupported.

Reset
REQ-028 While rst is high, SHALL force state to IDLE and clear the counter and bit index.
REQ-029 While rst is high, SHALL set rx_data = 8'h00, rx_valid = 0, frame_err = 0 and overrun = 0, and set the synchronizer flops to 1.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no rx_valid, frame_err or overrun.
REQ-031 After release, a frame SHALL start only on a fresh falling edge.

Verification (SOURCE_CLK=16, TARGET_CLK=1, so CLKS_PER_BIT=16 and HALF_BIT=8)
REQ-032 Send 0xA5 with a valid stop bit and rx_ready=0 -> rx_data=8'hA5 and rx_valid=1 one cycle after the stop sample, held until rx_ready=1, then rx_valid=0 the next cycle.
REQ-033 Send 0x3C with the stop bit low -> a single one-cycle frame_err pulse, rx_valid stays 0, rx_data unchanged.
REQ-034 Drive ftdi_rx low for 4 cycles, then high -> no state change beyond START, and no rx_valid, frame_err or overrun.
REQ-035 Send 0x11 then 0x22 back-to-back with rx_ready=0 -> overrun pulse at the completion of 0x22, rx_data remains 8'h11.
REQ-036 Send 0x55 then 0x66 with rx_ready pulsed in the exact cycle 0x66 completes -> rx_data=8'h66, rx_valid stays 1, no overrun.
REQ-037 Assert rst during the 4th data bit of 0xFF, release it, then send 0x81 -> only 0x81 is delivered, with no error pulses.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer and a valid/ready byte output.
// Frames are sampled mid-bit. Stop-bit errors and dropped bytes are reported as one-cycle pulses.
module uart_rx #(
    parameter int CNTR_W     = 32,
    parameter int SOURCE_CLK = 12000000,
    parameter int TARGET_CLK = 9600
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic       ftdi_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CLKS_PER_BIT = SOURCE_CLK / TARGET_CLK;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam logic [CNTR_W-1:0] BIT_LAST  = CNTR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNTR_W-1:0] HALF_LAST = CNTR_W'(HALF_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic              sync1_q, sync2_q, prev_q;
    logic [1:0]        state_q, state_d;
    logic [CNTR_W-1:0] cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d, data_q, data_d;
    logic              valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic              rx_s, done, accept;

    assign rx_s      = sync2_q;
    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        done    = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_s) state_d = START;
            end
            START: if (cnt_q == HALF_LAST) begin
                cnt_d   = '0;
                idx_d   = 3'd0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt_q == BIT_LAST) begin
                cnt_d   = '0;
                shift_d = {rx_s, shift_q[7:1]};
                idx_d   = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = STOP;
            end
            default: if (cnt_q == BIT_LAST) begin
                cnt_d   = '0;
                state_d = IDLE;
                done    = rx_s;
                ferr_d  = !rx_s;
            end
        endcase
        // A completing byte may replace the held one only if that byte is being accepted now
        accept  = valid_q && rx_ready;
        valid_d = done || (valid_q && !accept);
        data_d  = (done && (!valid_q || accept)) ? shift_q : data_q;
        ovr_d   = done && valid_q && !accept;
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= ftdi_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end
endmodule
